sub_bytes_seq: RTL and testbench



---
 rtl/sub_bytes_seq.sv | 135 +++++++++++++
 tb/tb_sub_bytes_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes / InvSubBytes engine: substitutes LANES bytes of a 128-bit state per
// clock, with a valid/ready handshake on both sides.
module sub_bytes_seq #(
   parameter int unsigned LANES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         in_inv,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   localparam int unsigned CYC = 16 / LANES;
   localparam int unsigned CW  = (CYC > 1) ? $clog2(CYC) : 1;

   if (!(LANES inside {1, 2, 4, 8, 16})) begin : g_bad_lanes
      $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
   end

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e         state_q;
   logic [CW-1:0]  cnt_q;
   logic [127:0]   work_q;
   logic           inv_q;
   logic [127:0]   work_sub;

   // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse, and maps 0 to 0 as AES requires
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] r;
      sq = a;
      r  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int unsigned n);
      return (b << n) | (b >> (8 - n));
   endfunction

   // Forward cell: inversion followed by the affine transform
   function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
   endfunction

   // Inverse cell: inverse affine transform followed by inversion
   function automatic logic [7:0] sbox_inv(input logic [7:0] a);
      return gf_inv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
   endfunction

   always_comb begin
      int unsigned base;
      logic [7:0]  b;
      work_sub = work_q;
      base     = 32'(cnt_q) * LANES;
      for (int unsigned l = 0; l < LANES; l++) begin
         b = work_q[(base + l) * 8 +: 8];
         work_sub[(base + l) * 8 +: 8] = inv_q ? sbox_inv(b) : sbox_fwd(b);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         work_q    <= '0;
         inv_q     <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  work_q   <= in_data;
                  inv_q    <= in_inv;
                  cnt_q    <= '0;
                  state_q  <= StBusy;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            StBusy: begin
               work_q <= work_sub;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == CW'(CYC - 1)) begin
                  state_q   <= StDone;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
               end
            end
            StDone: begin
               if (out_ready) begin
                  state_q   <= StIdle;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state_q   <= StIdle;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   assign out_data = work_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Scoreboard bench for sub_bytes_seq: one instance per legal LANES value, driven one at a time;
// a monitor pops expected results as each instance raises out_valid.
module tb_sub_bytes_seq;

   localparam int NI = 5;

   logic         clk;
   logic         rst_n;
   logic [127:0] in_data;
   logic         in_inv;
   logic         out_ready;
   logic         iv [NI];
   logic         ir [NI];
   logic         ov [NI];
   logic         bz [NI];
   logic [127:0] od [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      sub_bytes_seq #(.LANES(1 << g)) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (iv[g]),
         .in_ready  (ir[g]),
         .in_data   (in_data),
         .in_inv    (in_inv),
         .out_valid (ov[g]),
         .out_ready (out_ready),
         .out_data  (od[g]),
         .busy      (bz[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [127:0] data;
      logic [31:0]  k;
      logic [31:0]  t;
   } exp_t;
   exp_t sb_q[$];

   localparam logic [127:0] PLAIN = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] SUBST = 128'hd42711aee0bf98f1b8b45de51e415230;

   logic [2047:0] sbox_bits;
   initial sbox_bits = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return sbox_bits[(255 - int'(b)) * 8 +: 8];
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pop on each rising out_valid, then hold-check while the output waits.
   logic         ov_prev [NI];
   logic [127:0] held [NI];
   initial for (int k = 0; k < NI; k++) ov_prev[k] = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      for (int k = 0; k < NI; k++) begin
         if (ov[k] === 1'b1 && ov_prev[k] !== 1'b1) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL stale_out_valid: lanes %0d raised out_valid with nothing pending",
                        1 << k);
            end else begin
               e = sb_q.pop_front();
               chk("out_instance", 128'(k), 128'(e.k));
               chk("latency", 128'(cyc - e.t), 128'(16 >> e.k));
               chk("out_data", od[k], e.data);
               held[k] = e.data;
            end
         end else if (ov[k] === 1'b1) begin
            chk("hold_out_data", od[k], held[k]);
            chk("hold_in_ready", 128'(ir[k]), 128'(0));
         end
         ov_prev[k] = ov[k];
      end
   end

   task automatic send(input int k, input logic [127:0] d, input logic inv,
                       input logic [127:0] exp);
      int n;
      exp_t e;
      @(negedge clk);
      in_data = d;
      in_inv  = inv;
      iv[k]   = 1'b1;
      n = 0;
      while (ir[k] !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (ir[k] !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready never rose for lanes %0d", 1 << k);
      end else begin
         e.data = exp;
         e.k    = 32'(k);
         e.t    = cyc + 1;
         sb_q.push_back(e);
         @(posedge clk);
      end
      #1 iv[k] = 1'b0;
   endtask

   task automatic wait_done(input int k);
      int n;
      n = 0;
      while (!(sb_q.size() == 0 && ov[k] === 1'b0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 300) begin
         errors++;
         $display("FAIL done_timeout: lanes %0d pending %0d", 1 << k, sb_q.size());
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      in_data   = '0;
      in_inv    = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < NI; k++) iv[k] = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         chk("rst_in_ready", 128'(ir[k]), 128'(1));
         chk("rst_out_valid", 128'(ov[k]), 128'(0));
         chk("rst_busy", 128'(bz[k]), 128'(0));
         chk("rst_out_data", od[k], 128'h0);
      end
      rst_n = 1'b1;

      // Forward FIPS-197 vector with 4 lanes, busy visible right after accept
      send(2, PLAIN, 1'b0, SUBST);
      chk("busy_after_accept", 128'(bz[2]), 128'(1));
      wait_done(2);

      // Inverse round trip for every lane count
      for (int k = 0; k < NI; k++) begin
         send(k, SUBST, 1'b1, PLAIN);
         wait_done(k);
      end

      // Exhaustive byte check at 16 lanes, back to back
      for (int b = 0; b < 256; b++) begin : exh
         logic [7:0] s;
         s = sbox(8'(b));
         send(4, {16{8'(b)}}, 1'b0, {16{s}});
         send(4, {16{s}}, 1'b1, {16{8'(b)}});
      end
      wait_done(4);

      // Backpressure: output held for 10 cycles while inputs toggle
      out_ready = 1'b0;
      send(2, PLAIN, 1'b0, SUBST);
      begin
         int n;
         n = 0;
         while (ov[2] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
         end
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         iv[2]   = ~iv[2];
         in_data = ~in_data;
         in_inv  = ~in_inv;
      end
      @(negedge clk);
      iv[2]     = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_out_valid_drop", 128'(ov[2]), 128'(0));
      chk("bp_in_ready_rise", 128'(ir[2]), 128'(1));
      wait_done(2);

      // Mode latching: in_inv toggles throughout the 16 busy cycles
      send(0, PLAIN, 1'b0, SUBST);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         in_inv = ~in_inv;
      end
      wait_done(0);

      // Reset with cnt == 2 at 2 lanes, then a fresh block
      send(1, SUBST, 1'b1, PLAIN);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      sb_q.delete();
      #1;
      chk("mid_rst_in_ready", 128'(ir[1]), 128'(1));
      chk("mid_rst_out_valid", 128'(ov[1]), 128'(0));
      chk("mid_rst_busy", 128'(bz[1]), 128'(0));
      chk("mid_rst_out_data", od[1], 128'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("post_rst_no_valid", 128'(ov[1]), 128'(0));
      send(1, PLAIN, 1'b0, SUBST);
      wait_done(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
